// File: rtl/hack_rom_loader_pkg.sv
// Shared definitions for the Hack ROM boot loader: word width, default ROM geometry
// and the loader FSM state encoding.
package hack_rom_loader_pkg;

  localparam int unsigned HackWordW    = 16;
  localparam int unsigned DefaultAddrW = 15;
  localparam int unsigned DefaultDepth = 32768;

  typedef enum logic [2:0] {
    StLenHi  = 3'd0,
    StLenLo  = 3'd1,
    StDataHi = 3'd2,
    StDataLo = 3'd3,
    StCheck  = 3'd4,
    StHold   = 3'd5,
    StRun    = 3'd6,
    StError  = 3'd7
  } state_e;

  // States in which the loader consumes a stream byte.
  function automatic logic accepts_byte(input state_e s);
    return (s == StLenHi) || (s == StLenLo) || (s == StDataHi) ||
           (s == StDataLo) || (s == StCheck);
  endfunction

endpackage

// File: rtl/hack_rom_loader_assembler.sv
// Pairs HI/LO stream bytes into Hack words, issues one registered ROM write per word
// and keeps the running XOR checksum of all data bytes.
module hack_rom_loader_assembler
  import hack_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hi_fire,
  input  logic                 lo_fire,
  input  logic [7:0]           in_data,
  output logic                 rom_we,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [HackWordW-1:0] rom_wdata,
  output logic [7:0]           csum,
  output logic [ADDR_W:0]      word_cnt
);

  logic [7:0] hi_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q      <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      csum      <= '0;
      word_cnt  <= '0;
    end else begin
      rom_we <= lo_fire;
      if (hi_fire) begin
        hi_q <= in_data;
      end
      if (lo_fire) begin
        // word_cnt is one bit wider than the address so a full 2**ADDR_W image
        // can be counted without wrapping; the address uses the low bits.
        rom_addr  <= word_cnt[ADDR_W-1:0];
        rom_wdata <= {hi_q, in_data};
        word_cnt  <= word_cnt + 1'b1;
      end
      if (hi_fire || lo_fire) begin
        csum <= csum ^ in_data;
      end
    end
  end

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader ahead of the Hack instruction ROM: receives a length-prefixed, checksummed
// byte image, writes it from address 0 and holds the CPU in reset until it is verified.
module hack_rom_loader
  import hack_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 rom_we,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [HackWordW-1:0] rom_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1) + 1;

  state_e           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      len_q, len_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic             fire;
  logic             hi_fire;
  logic             lo_fire;
  logic [15:0]      len_word;
  logic             last_word;
  logic [7:0]       csum;
  logic [ADDR_W:0]  word_cnt;

  hack_rom_loader_assembler #(
    .ADDR_W(ADDR_W)
  ) u_assembler (
    .clock    (clock),
    .reset    (reset),
    .hi_fire  (hi_fire),
    .lo_fire  (lo_fire),
    .in_data  (in_data),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata),
    .csum     (csum),
    .word_cnt (word_cnt)
  );

  assign in_ready  = accepts_byte(state_q);
  assign fire      = in_valid & in_ready;
  assign len_word  = {len_hi_q, in_data};
  // word_cnt still holds the index of the word whose LO byte is arriving now.
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    hold_d   = hold_q;
    hi_fire  = 1'b0;
    lo_fire  = 1'b0;
    unique case (state_q)
      StLenHi: begin
        if (fire) begin
          len_hi_d = in_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (fire) begin
          len_d = len_word;
          if (len_word == 16'd0) begin
            state_d = StCheck;
          end else if (32'(len_word) > DEPTH) begin
            state_d = StError;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        hi_fire = fire;
        if (fire) begin
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        lo_fire = fire;
        if (fire) begin
          state_d = last_word ? StCheck : StDataHi;
        end
      end
      StCheck: begin
        hold_d = '0;
        if (fire) begin
          state_d = (in_data == csum) ? StHold : StError;
        end
      end
      StHold: begin
        // Stays RESET_HOLD+1 cycles so done rises RESET_HOLD+1 cycles after CSUM.
        if (hold_q == HoldW'(RESET_HOLD)) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun:   state_d = StRun;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StLenHi;
      len_hi_q <= '0;
      len_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      hold_q   <= hold_d;
    end
  end

  assign cpu_reset = (state_q != StRun);
  assign done      = (state_q == StRun);
  assign error     = (state_q == StError);

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: frame vectors on a full-size and a 4-word
// loader, ROM writes checked against a scoreboard of expected {addr, data}.
module tb_hack_rom_loader;

  localparam int Hold = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic        rom_we0, rom_we1;
  logic [14:0] rom_addr0;
  logic [1:0]  rom_addr1;
  logic [15:0] rom_wdata0, rom_wdata1;
  logic        cpu_reset0, cpu_reset1;
  logic        done0, done1;
  logic        error0, error1;

  always #5 clock = ~clock;

  hack_rom_loader #(.ADDR_W(15), .DEPTH(32768), .RESET_HOLD(Hold)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid0), .in_data(in_data),
    .in_ready(in_ready0), .rom_we(rom_we0), .rom_addr(rom_addr0), .rom_wdata(rom_wdata0),
    .cpu_reset(cpu_reset0), .done(done0), .error(error0)
  );

  hack_rom_loader #(.ADDR_W(2), .DEPTH(4), .RESET_HOLD(Hold)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .in_data(in_data),
    .in_ready(in_ready1), .rom_we(rom_we1), .rom_addr(rom_addr1), .rom_wdata(rom_wdata1),
    .cpu_reset(cpu_reset1), .done(done1), .error(error1)
  );

  typedef struct {
    logic [95:0] raw;   // bytes left-justified, byte 0 in [95:88]
    int          n;
    bit          gap;
    int          dut;
    bit          exp_done;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          dut;
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc;
  int   sel     = 0;
  bit   mon_en  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_write(input int d, input logic we, input logic [14:0] a,
                           input logic [15:0] wd);
    wr_t e;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rom_we: dut%0d addr %0h data %0h", d, a, wd);
      end else begin
        e = exp_q.pop_front();
        check("write_dut", d, e.dut);
        check("write_addr", {17'd0, a}, {17'd0, e.addr});
        check("write_data", {16'd0, wd}, {16'd0, e.data});
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon_write(0, rom_we0, rom_addr0, rom_wdata0);
      mon_write(1, rom_we1, {13'd0, rom_addr1}, rom_wdata1);
      check("cpu_reset_vs_done0", {31'd0, cpu_reset0}, {31'd0, ~done0});
      check("cpu_reset_vs_done1", {31'd0, cpu_reset1}, {31'd0, ~done1});
    end
  end

  function automatic logic rdy();
    return (sel == 1) ? in_ready1 : in_ready0;
  endfunction

  function automatic vec_t mk(input int n, input logic [95:0] raw, input bit gap,
                              input int dut, input bit d, input bit e, input int lat);
    vec_t v;
    v.raw = raw; v.n = n; v.gap = gap; v.dut = dut;
    v.exp_done = d; v.exp_err = e; v.exp_lat = lat;
    return v;
  endfunction

  task automatic set_valid(input logic v);
    in_valid0 = (sel == 0) ? v : 1'b0;
    in_valid1 = (sel == 1) ? v : 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int tries = 0;
    in_data = b;
    set_valid(1'b1);
    while (!rdy() && tries < 20) begin
      @(posedge clock);
      @(negedge clock);
      tries++;
    end
    if (!rdy()) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h not accepted, got in_ready 0 expected 1", b);
      set_valid(1'b0);
      return;
    end
    @(posedge clock);
    @(negedge clock);
    last_acc = cyc;
    set_valid(1'b0);
    if (gap) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic send_bytes(input vec_t v, input int upto);
    logic [7:0]  b, prev;
    logic [15:0] nwords;
    int          depth;
    wr_t         w;
    nwords = v.raw[95:80];
    depth  = (v.dut == 1) ? 4 : 32768;
    prev   = 8'h00;
    for (int k = 0; k < upto; k++) begin
      b = v.raw[95-8*k -: 8];
      if (k >= 2 && k < 2 + 2 * int'(nwords) && ((k - 2) % 2) == 1 &&
          int'(nwords) <= depth) begin
        w.dut  = v.dut;
        w.addr = 15'((k - 3) / 2);
        w.data = {prev, b};
        exp_q.push_back(w);
      end
      send_byte(b, v.gap);
      prev = b;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_data   = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    exp_q.delete();
    mon_en = 1'b1;
    check("rst_rom_we", {31'd0, rom_we0}, 32'd0);
    check("rst_rom_addr", {17'd0, rom_addr0}, 32'd0);
    check("rst_rom_wdata", {16'd0, rom_wdata0}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_error", {31'd0, error0}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check("rst_error_small", {31'd0, error1}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int tries = 0;
    logic d, e, cr, rd;
    do_reset();
    sel = v.dut;
    send_bytes(v, v.n);
    while (!(((sel == 1) ? (done1 | error1) : (done0 | error0))) && tries < 30) begin
      @(posedge clock);
      @(negedge clock);
      tries++;
    end
    d  = (sel == 1) ? done1 : done0;
    e  = (sel == 1) ? error1 : error0;
    cr = (sel == 1) ? cpu_reset1 : cpu_reset0;
    rd = (sel == 1) ? in_ready1 : in_ready0;
    check($sformatf("v%0d_latency", idx), cyc - last_acc, v.exp_lat);
    check($sformatf("v%0d_done", idx), {31'd0, d}, {31'd0, v.exp_done});
    check($sformatf("v%0d_error", idx), {31'd0, e}, {31'd0, v.exp_err});
    check($sformatf("v%0d_cpu_reset", idx), {31'd0, cr}, {31'd0, ~v.exp_done});
    check($sformatf("v%0d_in_ready", idx), {31'd0, rd}, 32'd0);
    check($sformatf("v%0d_writes_left", idx), exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; in_data = 8'h00;
    // Good 3-word image, csum EA^10^FC^10^00^00 = 16.
    vecs[0] = mk(9, {8'h00, 8'h03, 8'hEA, 8'h10, 8'hFC, 8'h10, 8'h00, 8'h00, 8'h16, 24'h0},
                 1'b0, 0, 1'b1, 1'b0, Hold + 1);
    vecs[1] = mk(9, {8'h00, 8'h03, 8'hEA, 8'h10, 8'hFC, 8'h10, 8'h00, 8'h00, 8'h16, 24'h0},
                 1'b1, 0, 1'b1, 1'b0, Hold + 1);
    vecs[2] = mk(9, {8'h00, 8'h03, 8'hEA, 8'h10, 8'hFC, 8'h10, 8'h00, 8'h00, 8'h17, 24'h0},
                 1'b0, 0, 1'b0, 1'b1, 0);
    vecs[3] = mk(3, {8'h00, 8'h00, 8'h00, 72'h0}, 1'b0, 0, 1'b1, 1'b0, Hold + 1);
    vecs[4] = mk(3, {8'h00, 8'h00, 8'h01, 72'h0}, 1'b0, 0, 1'b0, 1'b1, 0);
    // 4-word loader: N=5 rejected at LEN_LO, N=4 fills addresses 0..3 without wrap.
    vecs[5] = mk(2, {8'h00, 8'h05, 80'h0}, 1'b0, 1, 1'b0, 1'b1, 0);
    vecs[6] = mk(11, {8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                      8'h08, 8'h00}, 1'b1, 1, 1'b1, 1'b0, Hold + 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset mid-frame after three data bytes, then reload the full image from scratch.
    do_reset();
    sel = 0;
    send_bytes(vecs[0], 5);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("midframe_writes_left", exp_q.size(), 32'd0);
    check("midframe_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    run_vec(vecs[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
